// File: rtl/uart_rx_fifo_gen.sv
// ============================================================================
// Module   : uart_rx_fifo_gen
// Brief    : Oversampling UART receiver with majority vote, configurable frame
//            format, break detection and a show-ahead RX FIFO with flags.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_fifo_gen #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DEPTH      = 8,
    parameter int DIV_W      = 16,
    parameter int RTS_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   rx,
    input  logic [DIV_W-1:0]       divisor,
    input  logic [1:0]             parity_mode,
    input  logic                   two_stop,
    input  logic                   clear,
    input  logic                   rd_en,
    output logic [DATA_BITS+1:0]   rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   rts,
    output logic                   overrun,
    output logic                   break_det,
    output logic                   busy
);

    localparam int C_AW  = $clog2(DEPTH);
    localparam int C_CW  = C_AW + 1;
    localparam int C_SW  = $clog2(OVERSAMPLE);
    localparam int C_BW  = $clog2(DATA_BITS);
    localparam int C_EW  = DATA_BITS + 2;
    localparam int C_MID = OVERSAMPLE / 2;

    localparam logic [C_SW-1:0] C_SAMP_LO   = C_SW'(C_MID - 1);
    localparam logic [C_SW-1:0] C_SAMP_MID  = C_SW'(C_MID);
    localparam logic [C_SW-1:0] C_SAMP_HI   = C_SW'(C_MID + 1);
    localparam logic [C_SW-1:0] C_SAMP_LAST = C_SW'(OVERSAMPLE - 1);
    localparam logic [C_BW-1:0] C_LAST_BIT  = C_BW'(DATA_BITS - 1);
    localparam logic [C_CW-1:0] C_FULL      = C_CW'(DEPTH);
    localparam logic [C_CW-1:0] C_RTS_LVL   = C_CW'(DEPTH - RTS_MARGIN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP1    = 3'd4,
        S_STOP2    = 3'd5,
        S_BRK_WAIT = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q, rx_prev_q;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [DIV_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [C_SW-1:0]       samp_q, samp_d;
    logic [C_BW-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [1:0]            maj_q, maj_d;
    logic [1:0]            par_q, par_d;
    logic                  two_q, two_d;
    logic                  pbit_q, pbit_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  push_q, push_d;
    logic [C_EW-1:0]       push_data_q, push_data_d;
    logic                  brk_q, brk_d;

    logic [C_EW-1:0]       mem_q [DEPTH];
    logic [C_AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [C_CW-1:0]       count_q;
    logic                  overrun_q;

    logic                  w_rx, w_fall, w_tick, w_vote, w_decide, w_bit_end;
    logic                  w_par_en, w_parity, w_pop, w_full, w_push;
    logic [DIV_W-1:0]      w_div_eff;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    assign w_rx      = sync2_q;
    assign w_fall    = rx_prev_q & ~sync2_q;
    assign w_tick    = (tick_cnt_q == '0);
    assign w_vote    = (maj_q[0] & maj_q[1]) | (maj_q[0] & w_rx) | (maj_q[1] & w_rx);
    assign w_decide  = w_tick && (samp_q == C_SAMP_HI);
    assign w_bit_end = w_tick && (samp_q == C_SAMP_LAST);
    assign w_par_en  = (par_q == 2'b01) || (par_q == 2'b10);
    assign w_parity  = (^shift_q) ^ w_vote;
    assign w_div_eff = (divisor == '0) ? DIV_W'(1) : divisor;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            div_q       <= DIV_W'(1);
            tick_cnt_q  <= '0;
            samp_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            maj_q       <= 2'b11;
            par_q       <= 2'b00;
            two_q       <= 1'b0;
            pbit_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            brk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_q      <= samp_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            maj_q       <= maj_d;
            par_q       <= par_d;
            two_q       <= two_d;
            pbit_q      <= pbit_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            brk_q       <= brk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tick_cnt_d  = tick_cnt_q;
        samp_d      = samp_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        maj_d       = maj_q;
        par_d       = par_q;
        two_d       = two_q;
        pbit_d      = pbit_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        brk_d       = 1'b0;

        // Tick and sample bookkeeping runs only while a frame is being timed.
        if (state_q != S_IDLE && state_q != S_BRK_WAIT) begin
            tick_cnt_d = w_tick ? (div_q - DIV_W'(1)) : (tick_cnt_q - DIV_W'(1));
            if (w_tick) begin
                samp_d = w_bit_end ? '0 : (samp_q + C_SW'(1));
                if (samp_q == C_SAMP_LO)  maj_d[0] = w_rx;
                if (samp_q == C_SAMP_MID) maj_d[1] = w_rx;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (w_fall) begin
                    state_d    = S_START;
                    div_d      = w_div_eff;
                    tick_cnt_d = w_div_eff - DIV_W'(1);
                    samp_d     = '0;
                    bit_idx_d  = '0;
                    par_d      = parity_mode;
                    two_d      = two_stop;
                    pbit_d     = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            S_START: begin
                if (w_decide && w_vote) state_d = S_IDLE;
                else if (w_bit_end)     state_d = S_DATA;
            end
            S_DATA: begin
                if (w_decide) shift_d = {w_vote, shift_q[DATA_BITS-1:1]};
                if (w_bit_end) begin
                    if (bit_idx_q == C_LAST_BIT) begin
                        bit_idx_d = '0;
                        state_d   = w_par_en ? S_PARITY : S_STOP1;
                    end else begin
                        bit_idx_d = bit_idx_q + C_BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_decide) begin
                    pbit_d = w_vote;
                    perr_d = (par_q == 2'b01) ? w_parity : ~w_parity;
                end
                if (w_bit_end) state_d = S_STOP1;
            end
            S_STOP1: begin
                if (w_decide) begin
                    if ((shift_q == '0) && !(w_par_en && pbit_q) && !w_vote) begin
                        brk_d   = 1'b1;
                        state_d = S_BRK_WAIT;
                    end else begin
                        ferr_d = ~w_vote;
                        if (!two_q) begin
                            push_d      = 1'b1;
                            push_data_d = {perr_q, ~w_vote, shift_q};
                            state_d     = S_IDLE;
                        end
                    end
                end else if (w_bit_end) begin
                    state_d = S_STOP2;
                end
            end
            S_STOP2: begin
                if (w_decide) begin
                    push_d      = 1'b1;
                    push_data_d = {perr_q, ferr_q | ~w_vote, shift_q};
                    state_d     = S_IDLE;
                end
            end
            S_BRK_WAIT: begin
                if (w_rx) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            state_d = S_IDLE;
            push_d  = 1'b0;
            brk_d   = 1'b0;
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign w_pop  = rd_en && (count_q != '0);
    assign w_full = (count_q == C_FULL);
    assign w_push = push_q && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !clear) mem_q[wr_ptr_q] <= push_data_q;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else if (clear) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + C_AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + C_AW'(1);
            if (w_push && !w_pop)      count_q <= count_q + C_CW'(1);
            else if (!w_push && w_pop) count_q <= count_q - C_CW'(1);
            if (push_q && !w_push) overrun_q <= 1'b1;
        end
    end

    assign rd_valid  = (count_q != '0);
    assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign rts       = (count_q >= C_RTS_LVL);
    assign overrun   = overrun_q;
    assign break_det = brk_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo_gen.sv
// ============================================================================
// Module   : tb_uart_rx_fifo_gen
// Brief    : Directed self-checking bench for uart_rx_fifo_gen (default params).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo_gen;

    logic        clk = 1'b0;
    logic        nReset;
    logic        rx;
    logic [15:0] divisor;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        clear;
    logic        rd_en;
    logic [9:0]  rd_data;
    logic        rd_valid;
    logic [3:0]  count;
    logic        rts;
    logic        overrun;
    logic        break_det;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int t_valid  = -1;
    int t_ref    = 158;
    int brk_seen = 0;
    int g_glitch = -1;
    int g_pop    = -1;
    int g_max    = 1000000;

    uart_rx_fifo_gen dut (
        .clk        (clk),
        .nReset     (nReset),
        .rx         (rx),
        .divisor    (divisor),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
        .clear      (clear),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .rts        (rts),
        .overrun    (overrun),
        .break_det  (break_det),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (break_det) brk_seen++;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    // Drives one frame, one loop pass per clock; optional glitch, pop and truncation.
    task automatic send(input logic [7:0] data, input bit par_en, input logic pbit,
                        input logic stop1, input bit two, input int div);
        logic bits [0:11];
        int   n;
        int   bitc;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        n = 9;
        if (par_en) begin bits[n] = pbit; n = n + 1; end
        bits[n] = stop1; n = n + 1;
        if (two) begin bits[n] = 1'b1; n = n + 1; end
        bitc    = 16 * div;
        t_valid = -1;
        for (int c = 0; c < n * bitc && c < g_max; c++) begin
            rx = bits[c / bitc];
            if (c == g_glitch) rx = ~rx;
            rd_en = (c == g_pop);
            step();
            if (t_valid < 0 && rd_valid) t_valid = c + 1;
        end
        rd_en = 1'b0;
        rx    = 1'b1;
    endtask

    initial begin
        nReset = 1'b0; rx = 1'b1; divisor = 16'd1; parity_mode = 2'b00;
        two_stop = 1'b0; clear = 1'b0; rd_en = 1'b0;
        step(); step(); step();
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_count",    32'(count), 0);
        check("rst_rts",      32'(rts), 0);
        check("rst_overrun",  32'(overrun), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_break",    32'(break_det), 0);
        check("rst_rd_data",  32'(rd_data), 0);
        nReset = 1'b1;
        step(); step();

        // 8N1 0xA5, latency and pop
        send(8'hA5, 0, 0, 1, 0, 1);
        t_ref = t_valid;
        check("a5_latency_window", 32'((t_valid >= 152) && (t_valid <= 158)), 1);
        check("a5_data",     32'(rd_data), 32'h0A5);
        check("a5_count",    32'(count), 1);
        check("a5_valid",    32'(rd_valid), 1);
        pop();
        check("a5_pop_count", 32'(count), 0);
        check("a5_pop_valid", 32'(rd_valid), 0);

        // even parity: 0x03 has even ones, so parity bit 1 is an error
        parity_mode = 2'b01;
        send(8'h03, 1, 1, 1, 0, 1);
        check("par_err_data", 32'(rd_data), 32'h203);
        pop();
        send(8'h03, 1, 0, 1, 0, 1);
        check("par_ok_data", 32'(rd_data), 32'h003);
        pop();
        parity_mode = 2'b00;

        // framing error
        send(8'h5A, 0, 0, 0, 0, 1);
        check("ferr_data",  32'(rd_data), 32'h15A);
        check("ferr_count", 32'(count), 1);
        pop();

        // break: all-zero frame, stop low, line then held low
        brk_seen = 0;
        send(8'h00, 0, 0, 0, 0, 1);
        rx = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("brk_pulses",  32'(brk_seen), 1);
        check("brk_count",   32'(count), 0);
        check("brk_waiting", 32'(busy), 1);
        rx = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("brk_released", 32'(busy), 0);
        send(8'h3C, 0, 0, 1, 0, 1);
        check("post_brk_data", 32'(rd_data), 32'h03C);
        pop();

        // 2-cycle start glitch at divisor 4
        divisor = 16'd4;
        rx = 1'b0; step(); step();
        rx = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("glitch_busy", 32'(busy), 1);
        for (int i = 0; i < 80; i++) step();
        check("glitch_idle",  32'(busy), 0);
        check("glitch_count", 32'(count), 0);
        divisor = 16'd1;

        // single-cycle glitch in the middle of data bit 3
        g_glitch = 4 * 16 + 8;
        send(8'hC3, 0, 0, 1, 0, 1);
        g_glitch = -1;
        check("maj_data", 32'(rd_data), 32'h0C3);
        pop();

        // fill past full
        for (int i = 0; i < 9; i++) begin
            send(8'(8'h10 + i), 0, 0, 1, 0, 1);
            if (i == 4) begin
                check("fill5_count", 32'(count), 5);
                check("fill5_rts",   32'(rts), 0);
            end
            if (i == 5) begin
                check("fill6_count", 32'(count), 6);
                check("fill6_rts",   32'(rts), 1);
            end
            if (i == 7) begin
                check("fill8_count",   32'(count), 8);
                check("fill8_overrun", 32'(overrun), 0);
            end
        end
        check("ovr_count",   32'(count), 8);
        check("ovr_flag",    32'(overrun), 1);
        check("ovr_head",    32'(rd_data), 32'h010);
        clear = 1'b1; step(); clear = 1'b0;
        check("clr_count",   32'(count), 0);
        check("clr_overrun", 32'(overrun), 0);
        check("clr_valid",   32'(rd_valid), 0);
        check("clr_rts",     32'(rts), 0);

        // push and pop in the same cycle while full
        for (int i = 0; i < 8; i++) send(8'(8'h20 + i), 0, 0, 1, 0, 1);
        check("full_count", 32'(count), 8);
        g_pop = t_ref - 1;
        send(8'h28, 0, 0, 1, 0, 1);
        g_pop = -1;
        check("pp_count",   32'(count), 8);
        check("pp_overrun", 32'(overrun), 0);
        check("pp_head",    32'(rd_data), 32'h021);

        // reset in the middle of the data bits
        g_max = 60;
        send(8'h77, 0, 0, 1, 0, 1);
        g_max = 1000000;
        check("mid_busy", 32'(busy), 1);
        nReset = 1'b0;
        #1;
        check("mr_busy",    32'(busy), 0);
        check("mr_count",   32'(count), 0);
        check("mr_valid",   32'(rd_valid), 0);
        check("mr_rd_data", 32'(rd_data), 0);
        check("mr_rts",     32'(rts), 0);
        check("mr_overrun", 32'(overrun), 0);
        check("mr_break",   32'(break_det), 0);
        step(); step();
        nReset = 1'b1;
        step(); step(); step();
        send(8'h77, 0, 0, 1, 0, 1);
        check("after_rst_data",  32'(rd_data), 32'h077);
        check("after_rst_count", 32'(count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
